// File: rtl/sig_mod_pkg.sv
// Shared constants, types and helpers for the SIGNAL-field BPSK mapper (sig_mod).
// Holds FFT/symbol sizes, BPSK amplitude, pilot/null bin positions and FSM encoding.
package sig_mod_pkg;

    localparam int unsigned N_CBPS   = 48;
    localparam int unsigned N_FFT    = 64;
    localparam int unsigned SAMPLE_W = 12;

    localparam logic signed [SAMPLE_W-1:0] BPSK_AMP = 12'sd512;

    // Pilot bins in IFFT natural order; polarity p0 = +1.
    localparam logic [5:0] PILOT_BIN_POS0 = 6'd7;
    localparam logic [5:0] PILOT_BIN_POS1 = 6'd43;
    localparam logic [5:0] PILOT_BIN_POS2 = 6'd57;
    localparam logic [5:0] PILOT_BIN_NEG  = 6'd21;

    localparam logic signed [SAMPLE_W-1:0] PILOT_VAL_POS = BPSK_AMP;
    localparam logic signed [SAMPLE_W-1:0] PILOT_VAL_NEG = -BPSK_AMP;

    localparam logic [5:0] DC_BIN   = 6'd0;
    localparam logic [5:0] NULL_LO  = 6'd27;
    localparam logic [5:0] NULL_HI  = 6'd37;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StEmit = 2'd2
    } sig_state_e;

    function automatic logic signed [SAMPLE_W-1:0] bpsk(input logic b);
        return b ? BPSK_AMP : -BPSK_AMP;
    endfunction

    function automatic logic is_pilot(input logic [5:0] n);
        return (n == PILOT_BIN_POS0) || (n == PILOT_BIN_POS1) ||
               (n == PILOT_BIN_POS2) || (n == PILOT_BIN_NEG);
    endfunction

    function automatic logic is_null(input logic [5:0] n);
        return (n == DC_BIN) || ((n >= NULL_LO) && (n <= NULL_HI));
    endfunction

endpackage

// File: rtl/sig_intlv.sv
// Block interleaver address for the 48-bit SIGNAL field: bit k lands at 3*(k mod 16) + k/16.
module sig_intlv (
    input  logic [5:0] k_i,
    output logic [5:0] addr_o
);

    always_comb begin
        addr_o = 6'(k_i[3:0]) * 6'd3 + 6'(k_i[5:4]);
    end

endmodule

// File: rtl/sig_mod.sv
// SIGNAL-field deinterleave-free BPSK mapper: loads 48 coded bits, emits one 64-bin IFFT symbol.
// Optional pilots enabled by defining SIG_MOD_PILOT_EN; otherwise pilot bins output 0.
module sig_mod
    import sig_mod_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       di,
    input  logic                       di_vld,
    output logic                       di_rdy,
    output logic signed [SAMPLE_W-1:0] do_re,
    output logic signed [SAMPLE_W-1:0] do_im,
    output logic                       do_vld,
    output logic                       do_sym_start
);

    sig_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [47:0] bits_q;
    logic [6:0]  emit_q;
    logic [5:0]  wr_addr;
    logic        accept;

    assign accept = di_vld & di_rdy;
    assign do_im  = '0;

    sig_intlv u_intlv (
        .k_i    (cnt_q),
        .addr_o (wr_addr)
    );

    // Returns {valid, data index} for a bin; data subcarriers -26..26 minus pilots and DC.
    function automatic logic [6:0] bin_to_data(input logic [5:0] n);
        logic [6:0] r;
        r = '0;
        case (n) inside
            [6'd1:6'd6]:   r = {1'b1, n + 6'd23};
            [6'd8:6'd20]:  r = {1'b1, n + 6'd22};
            [6'd22:6'd26]: r = {1'b1, n + 6'd21};
            [6'd38:6'd42]: r = {1'b1, n - 6'd38};
            [6'd44:6'd56]: r = {1'b1, n - 6'd39};
            [6'd58:6'd63]: r = {1'b1, n - 6'd40};
            default:       r = '0;
        endcase
        return r;
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] bin_value(input logic [5:0]  n,
                                                             input logic [47:0] bits);
        logic [6:0]                  m;
        logic signed [SAMPLE_W-1:0]  v;
        m = bin_to_data(n);
        v = '0;
        if (is_null(n)) begin
            v = '0;
        end else if (m[6]) begin
            v = bpsk(bits[m[5:0]]);
        end else if (is_pilot(n)) begin
`ifdef SIG_MOD_PILOT_EN
            v = (n == PILOT_BIN_NEG) ? PILOT_VAL_NEG : PILOT_VAL_POS;
`else
            v = '0;
`endif
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bits_q       <= '0;
            emit_q       <= '0;
            di_rdy       <= 1'b1;
            do_vld       <= 1'b0;
            do_sym_start <= 1'b0;
            do_re        <= '0;
        end else begin
            unique case (state_q)
                StIdle, StLoad: begin
                    if (accept) begin
                        bits_q[wr_addr] <= di;
                        if (cnt_q == 6'(N_CBPS - 1)) begin
                            state_q <= StEmit;
                            cnt_q   <= '0;
                            di_rdy  <= 1'b0;
                        end else begin
                            state_q <= StLoad;
                            cnt_q   <= cnt_q + 6'd1;
                        end
                    end
                end
                StEmit: begin
                    // First EMIT cycle only launches bin 0; emit_q == N_FFT marks bin 63 done.
                    if (emit_q == 7'(N_FFT)) begin
                        state_q      <= StIdle;
                        emit_q       <= '0;
                        di_rdy       <= 1'b1;
                        do_vld       <= 1'b0;
                        do_sym_start <= 1'b0;
                        do_re        <= '0;
                    end else begin
                        do_vld       <= 1'b1;
                        do_sym_start <= (emit_q == 7'd0);
                        do_re        <= bin_value(emit_q[5:0], bits_q);
                        emit_q       <= emit_q + 7'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_mod.sv
// Self-checking bench for sig_mod: table of symbols plus reset / hold-valid corner sequences.
module tb_sig_mod;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               di = 1'b0;
    logic               di_vld = 1'b0;
    logic               di_rdy;
    logic signed [11:0] do_re;
    logic signed [11:0] do_im;
    logic               do_vld;
    logic               do_sym_start;

    always #5 clk = ~clk;

    sig_mod dut (
        .clk          (clk),
        .rst          (rst),
        .di           (di),
        .di_vld       (di_vld),
        .di_rdy       (di_rdy),
        .do_re        (do_re),
        .do_im        (do_im),
        .do_vld       (do_vld),
        .do_sym_start (do_sym_start)
    );

`ifdef SIG_MOD_PILOT_EN
    localparam int P_POS = 512;
    localparam int P_NEG = -512;
`else
    localparam int P_POS = 0;
    localparam int P_NEG = 0;
`endif

    typedef struct {
        int re;
        bit start;
    } exp_t;

    typedef struct {
        logic [47:0] bits;
        bit          gapped;
        int          chk_bin;
        int          chk_val;
    } vec_t;

    exp_t               sb[$];
    logic signed [31:0] cap[64];
    int                 run = 0;
    int                 n_tests = 0;
    int                 n_fail = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: interleave, then walk subcarriers -26..26 to number data bins.
    function automatic void push_expected(input logic [47:0] bits);
        logic [47:0] d;
        int          didx[64];
        int          c;
        exp_t        e;
        for (int n = 0; n < 64; n++) didx[n] = -1;
        for (int k = 0; k < 48; k++) d[3 * (k % 16) + k / 16] = bits[k];
        c = 0;
        for (int s = -26; s <= 26; s++) begin
            if (s != 0 && s != 7 && s != -7 && s != 21 && s != -21) begin
                didx[(s < 0) ? s + 64 : s] = c;
                c++;
            end
        end
        for (int n = 0; n < 64; n++) begin
            e.start = (n == 0);
            if (didx[n] >= 0)                      e.re = d[didx[n]] ? 512 : -512;
            else if (n == 7 || n == 43 || n == 57) e.re = P_POS;
            else if (n == 21)                      e.re = P_NEG;
            else                                   e.re = 0;
            sb.push_back(e);
        end
    endfunction

    // Output monitor: pops the scoreboard on every valid sample.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run = 0;
        end else if (do_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_do_vld", 32'(do_vld), 0);
            end else begin
                e = sb.pop_front();
                check("do_re", $signed(do_re), e.re);
                check("do_sym_start", 32'(do_sym_start), 32'(e.start));
            end
            check("do_im", $signed(do_im), 0);
            if (run < 64) cap[run] = $signed(do_re);
            run++;
        end else begin
            if (run > 0) begin
                check("vld_run_len", run, 64);
                run = 0;
            end
            check("idle_outputs_zero", {19'd0, do_re, do_im, do_sym_start}, 0);
        end
    end

    task automatic send_bit(input logic b);
        int g = 0;
        di     = b;
        di_vld = 1'b1;
        while (!di_rdy && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("send_rdy", 32'(di_rdy), 1);
        @(negedge clk);
        di_vld = 1'b0;
    endtask

    task automatic send_symbol(input logic [47:0] bits, input bit gapped, input bit hold);
        int n = 0;
        push_expected(bits);
        for (int k = 0; k < 48; k++) begin
            send_bit(bits[k]);
            if (gapped && k < 47) @(negedge clk);
        end
        check("rdy_low_in_emit", 32'(di_rdy), 0);
        check("vld_not_yet", 32'(do_vld), 0);
        if (hold) begin
            di_vld = 1'b1;
            di     = 1'b0;
        end
        @(negedge clk);
        check("vld_first", 32'(do_vld), 1);
        check("sym_start_first", 32'(do_sym_start), 1);
        while (!di_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("emit_len", n, 64);
    endtask

    task automatic check_reset_state();
        check("rst_di_rdy", 32'(di_rdy), 1);
        check("rst_do_vld", 32'(do_vld), 0);
        check("rst_do_re", $signed(do_re), 0);
        check("rst_do_im", $signed(do_im), 0);
        check("rst_sym_start", 32'(do_sym_start), 0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [47:0] ones;
        ones = '1;
        vecs[0] = '{bits: 48'h0,            gapped: 1'b0, chk_bin: 1,  chk_val: -512};
        vecs[1] = '{bits: 48'h2,            gapped: 1'b0, chk_bin: 41, chk_val: 512};
        vecs[2] = '{bits: 48'h0,            gapped: 1'b1, chk_bin: 21, chk_val: P_NEG};
        vecs[3] = '{bits: ones,             gapped: 1'b0, chk_bin: 63, chk_val: 512};
        vecs[4] = '{bits: 48'hAAAA_AAAA_AAAA, gapped: 1'b0, chk_bin: 1, chk_val: -512};
        vecs[5] = '{bits: ones,             gapped: 1'b1, chk_bin: 7,  chk_val: P_POS};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        for (int i = 0; i < 6; i++) begin
            send_symbol(vecs[i].bits, vecs[i].gapped, 1'b0);
            check($sformatf("vec%0d_bin%0d", i, vecs[i].chk_bin),
                  cap[vecs[i].chk_bin], vecs[i].chk_val);
        end

        // di_vld held high through EMIT, then an all-ones symbol.
        send_symbol(48'h0, 1'b0, 1'b1);
        send_symbol(ones, 1'b0, 1'b0);
        check("hold_then_ones_bin1", cap[1], 512);

        // Reset after 20 bits: partial symbol discarded.
        for (int k = 0; k < 20; k++) send_bit(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        send_symbol(ones, 1'b0, 1'b0);
        check("after_rst_load_bin40", cap[40], 512);

        // Reset mid-EMIT: remaining samples never appear.
        push_expected(48'h0);
        for (int k = 0; k < 48; k++) send_bit(1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_reset_state();
        repeat (80) @(negedge clk);
        send_symbol(ones, 1'b1, 1'b0);
        check("after_rst_emit_bin58", cap[58], 512);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
